// File: rtl/interpolator_sequencer.sv
// Strobe generator and sample/result sequencer for the 10x interpolator.
// Optional stats counters: define INTERP_SEQ_STATS_EN.
module interpolator_sequencer #(
  parameter int DIV   = 4,
  parameter int TICKS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        clk_en,
  output logic        clk_en_10x,
  output logic [7:0]  sample_x0,
  output logic [7:0]  sample_x1,
  input  logic        end_stage,
  input  logic [79:0] y_bus,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clear_flags,
  output logic        underrun,
  output logic        overrun
`ifdef INTERP_SEQ_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] underrun_count
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] DIV_MAX  = 4'(DIV - 1);
  localparam logic [3:0] TICK_MAX = 4'(TICKS - 1);

  state_t     state_q;
  logic [3:0] div_q;
  logic [3:0] tick_q;
  logic       clk_en_q;
  logic       ce10_q;
  logic [7:0] hold_q;
  logic       hold_v_q;
  logic [7:0] x0_q;
  logic [7:0] x1_q;
  logic [7:0] buf_q [10];
  logic [3:0] idx_q;
  logic       ov_q;
  logic       und_q;
  logic       ovr_q;

  logic accept_d;
  logic xfer_d;
  logic last_d;
  logic cap_d;
  logic cap_ok_d;
  logic und_set_d;
  logic ovr_set_d;

  assign in_ready  = (state_q == RUN) && !hold_v_q;
  assign accept_d  = in_valid && in_ready;
  assign xfer_d    = ov_q && out_ready;
  assign last_d    = xfer_d && (idx_q == 4'd9);
  assign cap_d     = end_stage && ce10_q;
  assign cap_ok_d  = cap_d && (!ov_q || last_d);
  assign und_set_d = clk_en_q && !hold_v_q;
  assign ovr_set_d = cap_d && !cap_ok_d;

  assign clk_en     = clk_en_q;
  assign clk_en_10x = ce10_q;
  assign sample_x0  = x0_q;
  assign sample_x1  = x1_q;
  assign out_valid  = ov_q;
  assign out_data   = ov_q ? buf_q[idx_q] : 8'h00;
  assign underrun   = und_q;
  assign overrun    = ovr_q;

  // RUN leaves only where the next tick-0 strobe would fire
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      clk_en_q <= 1'b0;
      ce10_q   <= 1'b0;
    end else begin
      clk_en_q <= 1'b0;
      ce10_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          div_q  <= '0;
          tick_q <= '0;
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (div_q == DIV_MAX) begin
            div_q <= '0;
            if (tick_q == 4'd0 && !enable) begin
              state_q <= IDLE;
            end else begin
              ce10_q   <= 1'b1;
              clk_en_q <= (tick_q == 4'd0);
              tick_q   <= (tick_q == TICK_MAX) ? 4'd0 : tick_q + 4'd1;
            end
          end else begin
            div_q <= div_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
    end else begin
      if (clk_en_q && hold_v_q) begin
        x0_q     <= x1_q;
        x1_q     <= hold_q;
        hold_v_q <= 1'b0;
      end
      if (accept_d) begin
        hold_q   <= in_data;
        hold_v_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 10; i++) buf_q[i] <= '0;
      idx_q <= '0;
      ov_q  <= 1'b0;
    end else if (cap_ok_d) begin
      for (int i = 0; i < 10; i++) buf_q[i] <= y_bus[8*i +: 8];
      idx_q <= '0;
      ov_q  <= 1'b1;
    end else if (xfer_d) begin
      if (last_d) begin
        idx_q <= '0;
        ov_q  <= 1'b0;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      und_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (clear_flags) begin
        und_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      if (und_set_d) und_q <= 1'b1;
      if (ovr_set_d) ovr_q <= 1'b1;
    end
  end

`ifdef INTERP_SEQ_STATS_EN
  logic [15:0] fc_q;
  logic [15:0] uc_q;

  assign frame_count    = fc_q;
  assign underrun_count = uc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fc_q <= '0;
      uc_q <= '0;
    end else if (clear_flags) begin
      fc_q <= {15'd0, clk_en_q};
      uc_q <= {15'd0, und_set_d};
    end else begin
      if (clk_en_q && fc_q != 16'hFFFF) fc_q <= fc_q + 16'd1;
      if (und_set_d && uc_q != 16'hFFFF) uc_q <= uc_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_interpolator_sequencer.sv
// Directed bench for interpolator_sequencer (DIV=4, TICKS=10).
module tb_interpolator_sequencer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clk_en;
  logic        clk_en_10x;
  logic [7:0]  sample_x0;
  logic [7:0]  sample_x1;
  logic        end_stage;
  logic [79:0] y_bus;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear_flags;
  logic        underrun;
  logic        overrun;
`ifdef INTERP_SEQ_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] underrun_count;
`endif

  interpolator_sequencer #(.DIV(4), .TICKS(10)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clk_en(clk_en), .clk_en_10x(clk_en_10x),
    .sample_x0(sample_x0), .sample_x1(sample_x1),
    .end_stage(end_stage), .y_bus(y_bus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clear_flags(clear_flags), .underrun(underrun), .overrun(overrun)
`ifdef INTERP_SEQ_STATS_EN
    , .frame_count(frame_count), .underrun_count(underrun_count)
`endif
  );

  int vec = 0;
  int miss = 0;
  int cnt = 0;
  int fidx = 0;
  logic [7:0] feed [32];
  logic       es_en;
  logic [3:0] tb_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub interpolator: flags the last tick of each frame
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_tick <= 4'd0;
    else if (clk_en_10x) tb_tick <= clk_en ? 4'd1 : tb_tick + 4'd1;
  assign end_stage = es_en && clk_en_10x && (tb_tick == 4'd9);

  task automatic cyc();
    bit hs;
    hs = in_valid && in_ready;
    @(negedge clk);
    cnt++;
    if (hs && fidx < 31) begin
      fidx++;
      in_data = feed[fidx];
    end
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return clk_en_10x;
      1: return clk_en;
      2: return end_stage;
      default: return !in_ready;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int budget, output int n);
    n = 0;
    while (!cond(kind) && n < budget) begin
      cyc();
      n++;
    end
    if (!cond(kind)) begin
      vec++; miss++;
      $display("FAIL wait_kind%0d: event absent after %0d clks", kind, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({clk_en, clk_en_10x, in_ready, out_valid} !== 4'b0) begin
      miss++;
      $display("FAIL reset_ctl: got %b want 0000",
               {clk_en, clk_en_10x, in_ready, out_valid});
    end
    vec++;
    if ({underrun, overrun} !== 2'b0) begin
      miss++;
      $display("FAIL reset_flags: got %b want 00", {underrun, overrun});
    end
    vec++;
    if ({sample_x0, sample_x1, out_data} !== 24'h0) begin
      miss++;
      $display("FAIL reset_data: got %h want 000000",
               {sample_x0, sample_x1, out_data});
    end
`ifdef INTERP_SEQ_STATS_EN
    vec++;
    if ({frame_count, underrun_count} !== 32'h0) begin
      miss++;
      $display("FAIL reset_stats: got %h want 0", {frame_count, underrun_count});
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_strobes();
    int n;
    in_valid = 1'b1;
    in_data  = feed[0];
    enable   = 1'b1;
    wait_for(0, 50, n);
    vec++;
    if (n != 5) begin
      miss++;
      $display("FAIL first_tick: got %0d clks want 5", n);
    end
    vec++;
    if (clk_en !== 1'b1) begin
      miss++;
      $display("FAIL tick0_clk_en: got %b want 1", clk_en);
    end
    cyc();
    wait_for(0, 50, n);
    vec++;
    if (n + 1 != 4 || clk_en !== 1'b0) begin
      miss++;
      $display("FAIL tick_gap: got %0d clks clk_en=%b want 4/0", n + 1, clk_en);
    end
    cyc();
    wait_for(1, 100, n);
    vec++;
    if (4 + 1 + n != 40 || clk_en_10x !== 1'b1) begin
      miss++;
      $display("FAIL frame_period: got %0d clks ce10=%b want 40/1",
               5 + n, clk_en_10x);
    end
    cyc();
    vec++;
    if (sample_x0 !== 8'h10 || sample_x1 !== 8'h20) begin
      miss++;
      $display("FAIL x_pair: got %h/%h want 10/20", sample_x0, sample_x1);
    end
  endtask

  task automatic test_stream();
    int n;
    out_ready = 1'b1;
    es_en = 1'b1;
    wait_for(2, 60, n);
    cyc();
    for (int i = 0; i < 10; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        miss++;
        $display("FAIL stream_y%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 8'(i));
      end
      cyc();
    end
    vec++;
    if (out_valid !== 1'b0) begin
      miss++;
      $display("FAIL stream_end: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    int n;
    int got;
    logic pv, pr;
    logic [7:0] pd;
    out_ready = 1'b0;
    got = 0;
    wait_for(2, 60, n);
    for (int k = 0; k < 40 && got < 10; k++) begin
      pv = out_valid; pd = out_data; pr = out_ready;
      cyc();
      out_ready = ~out_ready;
      if (pv && pr) begin
        vec++;
        if (pd !== 8'(got)) begin
          miss++;
          $display("FAIL stall_order: got %h want %h", pd, 8'(got));
        end
        got++;
      end else if (pv) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== pd) begin
          miss++;
          $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h",
                   out_valid, out_data, pd);
        end
      end
    end
    vec++;
    if (got != 10 || out_valid !== 1'b0) begin
      miss++;
      $display("FAIL stall_count: got %0d xfers valid=%b want 10/0",
               got, out_valid);
    end
  endtask

  task automatic test_overrun_boundary();
    int n;
    int cb;
    out_ready = 1'b0;
    wait_for(2, 60, n);
    cyc();
    vec++;
    if (out_valid !== 1'b1 || overrun !== 1'b0) begin
      miss++;
      $display("FAIL ovr_first: got v=%b ovr=%b want 1/0", out_valid, overrun);
    end
    wait_for(2, 60, n);
    cb = cnt;
    cyc();
    vec++;
    if (overrun !== 1'b1 || out_data !== 8'h00) begin
      miss++;
      $display("FAIL ovr_drop: got ovr=%b d=%h want 1/00", overrun, out_data);
    end
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    vec++;
    if (overrun !== 1'b0) begin
      miss++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
    while (cnt < cb + 31) cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        miss++;
        $display("FAIL bnd_y%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 8'(i));
      end
      if (i == 9) begin
        vec++;
        if (end_stage !== 1'b1) begin
          miss++;
          $display("FAIL bnd_align: got end_stage=%b want 1", end_stage);
        end
      end
      cyc();
    end
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || overrun !== 1'b0) begin
      miss++;
      $display("FAIL bnd_capture: got v=%b d=%h ovr=%b want 1/00/0",
               out_valid, out_data, overrun);
    end
    repeat (12) cyc();
  endtask

  task automatic test_underrun_skid();
    int n;
    logic [7:0] ex0, ex1, s;
    wait_for(3, 60, n);
    in_valid = 1'b0;
    ex1 = feed[fidx-1];
    ex0 = feed[fidx-2];
    wait_for(1, 60, n);
    cyc();
    vec++;
    if (sample_x0 !== ex0 || sample_x1 !== ex1 || underrun !== 1'b0) begin
      miss++;
      $display("FAIL pre_under: got %h/%h u=%b want %h/%h u=0",
               sample_x0, sample_x1, underrun, ex0, ex1);
    end
    wait_for(1, 60, n);
    cyc();
    vec++;
    if (sample_x0 !== ex0 || sample_x1 !== ex1 || underrun !== 1'b1) begin
      miss++;
      $display("FAIL underrun: got %h/%h u=%b want %h/%h u=1",
               sample_x0, sample_x1, underrun, ex0, ex1);
    end
`ifdef INTERP_SEQ_STATS_EN
    vec++;
    if (underrun_count !== 16'd1) begin
      miss++;
      $display("FAIL under_cnt: got %0d want 1", underrun_count);
    end
`endif
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    vec++;
    if (underrun !== 1'b0) begin
      miss++;
      $display("FAIL under_clear: got %b want 0", underrun);
    end
    wait_for(1, 60, n);
    s = feed[fidx];
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    vec++;
    if (underrun !== 1'b1 || in_ready !== 1'b0 ||
        sample_x0 !== ex0 || sample_x1 !== ex1) begin
      miss++;
      $display("FAIL skid_same: got u=%b rdy=%b %h/%h want 1/0 %h/%h",
               underrun, in_ready, sample_x0, sample_x1, ex0, ex1);
    end
`ifdef INTERP_SEQ_STATS_EN
    vec++;
    if (underrun_count !== 16'd1) begin
      miss++;
      $display("FAIL skid_cnt: got %0d want 1", underrun_count);
    end
`endif
    cyc();
    wait_for(1, 60, n);
    cyc();
    vec++;
    if (sample_x0 !== ex1 || sample_x1 !== s) begin
      miss++;
      $display("FAIL skid_next: got %h/%h want %h/%h",
               sample_x0, sample_x1, ex1, s);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    out_ready = 1'b1;
    wait_for(2, 60, n);
    repeat (6) cyc();
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    vec++;
    if ({clk_en, clk_en_10x, in_ready, out_valid, underrun, overrun} !== 6'b0 ||
        {sample_x0, sample_x1, out_data} !== 24'h0) begin
      miss++;
      $display("FAIL async_rst: got %b %h want 0",
               {clk_en, clk_en_10x, in_ready, out_valid, underrun, overrun},
               {sample_x0, sample_x1, out_data});
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_for(0, 50, n);
    vec++;
    if (n != 5 || clk_en !== 1'b1 || out_valid !== 1'b0) begin
      miss++;
      $display("FAIL restart: got %0d clks clk_en=%b v=%b want 5/1/0",
               n, clk_en, out_valid);
    end
  endtask

  initial begin
    feed[0] = 8'h10;
    feed[1] = 8'h20;
    for (int i = 2; i < 32; i++) feed[i] = 8'(17 * i + 16);
    for (int i = 0; i < 10; i++) y_bus[8*i +: 8] = 8'(i);
    reset_n = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    clear_flags = 1'b0;
    es_en = 1'b0;
    test_reset();
    test_strobes();
    test_stream();
    test_stall();
    test_overrun_boundary();
    test_underrun_skid();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
